jtdd_sync_meas: RTL and testbench
=================================

Name: jtdd_sync_meas

Overview:
Video timing receiver/analyser; consumes the HS/VS/HBL/VBL/pxl_cen set produced by the game's timing generator (or an external source).
- Recovers pixel and line position.
- Measures line and frame geometry, and declares lock once two consecutive frames match.
- Sits between the timing generator and downstream consumers (scan doubler, OSD, frame-rate monitor), which use the recovered counters and the lock flag.

Parameters:
CW, 9, width of all counters and measurement outputs; values saturate at 2^CW-1.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
pxl_cen  in  1  pixel clock enable; all sampling and counting happen only when high
HS  in  1  horizontal sync, active high
VS  in  1  vertical sync, active high
HBL  in  1  horizontal blank, active high
VBL  in  1  vertical blank, active high
hcnt  out  CW  recovered pixel position in line
vcnt  out  CW  recovered active line number
htotal  out  CW  pixels per line (HS rise to HS rise)
hactive  out  CW  pixels per line with HBL low
vtotal  out  CW  lines per frame (HS rises between VS rises)
vactive  out  CW  lines per frame whose HS rise saw VBL low
locked  out  1  geometry stable
err  out  1  one-clk pulse on lock loss or counter saturation

Behaviour:
- Reset (rst low at a clk edge): all outputs 0, all internal counters 0, state SEARCH, previous-sample registers 0. Reset mid-frame discards partial measurements.
- Input sampling: HS/VS/HBL/VBL are registered when pxl_cen=1. Edges are current sample vs previous sample. All updates are on the clk edge where pxl_cen=1. With pxl_cen=0, everything holds and err is 0.
- hcnt: set to 0 on the cen where an HBL falling edge is detected; otherwise increments by 1 per cen and saturates at 2^CW-1.
- vcnt: set to 0 on a VBL falling edge; otherwise increments on each HS rising edge while VBL is sampled low; saturates.
- Line counters run per cen:
  - pcnt: increments every cen.
  - acnt: increments every cen with HBL low.
  - On an HS rise, the line values are pcnt+1 and acnt (+1 if the current HBL is low). pcnt and acnt then restart at 0.
- Frame counters: lcnt increments and lact increments (when VBL low) on each HS rise. On a VS rise, the frame values are latched and lcnt/lact are cleared.
- Simultaneous HS rise and VS rise on the same cen: the line is counted into the ending frame first, then the frame is latched.
- Saturation: any internal counter reaching 2^CW-1 raises err for 1 clk, drops locked and forces state SEARCH.
- State machine (transitions only on a VS rise):
  - SEARCH: first VS rise -> MEASURE; start counting; outputs stay 0.
  - MEASURE: at VS rise, latch the candidate values {htotal, hactive, vtotal, vactive} (htotal/hactive taken from the last complete line) -> CHECK.
  - CHECK: at VS rise, compare the new frame with the candidate. Equal -> publish values to outputs, locked=1, -> LOCKED. Different -> replace the candidate, stay CHECK.
  - LOCKED: at every HS rise, compare the line values with htotal/hactive; at every VS rise, compare the frame values. Any mismatch -> err pulse, locked=0, candidate := new values, -> CHECK. Output measurement registers keep their last locked values until re-lock.
- Outputs htotal/hactive/vtotal/vactive change only on entering LOCKED. hcnt and vcnt are live in all states except SEARCH, where they are held at 0.
- Latency: locked rises on the clk edge of the cen detecting the third VS rise after reset (SEARCH, MEASURE, CHECK). err and locked respond on the same clk edge as the detected edge that causes them.

Test Plan:
- Generator at 384 px/line (HBL 128 px, HS 32 px), 272 lines (VBL 32 lines), pxl_cen every 4th clk -> locked=1 on the cen of the 3rd VS rise; htotal=384, hactive=256, vtotal=272, vactive=240; err never asserted.
- Same stream, check recovered position -> hcnt=0 at the first active pixel and 255 at the last; vcnt=0 on the first active line and 239 on the last.
- After lock, stretch one line to 385 px -> err 1-clk pulse at that HS rise, locked=0; restore 384 -> locked=1 again after 2 clean VS rises; htotal=384.
- Frames alternating 272/273 lines -> locked never asserts and state stays CHECK; then 272 steady -> locked after 2 VS rises.
- Hold HS/VS low for 600 cens after lock -> err pulse when pcnt hits 511, locked=0, state SEARCH; resume the stream -> re-lock after 3 VS rises.
- rst low for 1 clk mid-frame while locked -> all outputs 0 on the next clk; a VS rise coinciding with an HS rise is counted into the ending frame (vtotal=272, not 271).

Source files
------------

// File: rtl/jtdd_sync_meas.sv
// jtdd_sync_meas -- video timing receiver and geometry analyser.
//
// Watches the HS/VS/HBL/VBL set from a timing generator, recovers the pixel
// and line position, measures line/frame geometry and declares lock once two
// consecutive frames measure identically. All activity is qualified by
// pxl_cen; every edge detection compares the live input with the sample taken
// on the previous pixel enable.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-low reset
//   pxl_cen  pixel clock enable
//   HS, VS   horizontal / vertical sync, active high
//   HBL, VBL horizontal / vertical blank, active high
//   hcnt     pixel position in the line (0 on the first active pixel)
//   vcnt     active line number (0 on the first active line)
//   htotal   pixels per line, HS rise to HS rise
//   hactive  pixels per line with HBL low
//   vtotal   lines per frame, HS rises between VS rises
//   vactive  lines per frame whose HS rise saw VBL low
//   locked   geometry stable
//   err      one-clock pulse on lock loss or internal counter saturation
module jtdd_sync_meas #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          HS,
    input  logic          VS,
    input  logic          HBL,
    input  logic          VBL,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic [CW-1:0] htotal,
    output logic [CW-1:0] hactive,
    output logic [CW-1:0] vtotal,
    output logic [CW-1:0] vactive,
    output logic          locked,
    output logic          err
);

    localparam logic [CW-1:0] MAXV   = {CW{1'b1}};
    localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] SAT_M1 = MAXV - ONE;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic          r_hs, r_vs, r_hbl, r_vbl;
    logic [CW-1:0] r_pcnt, r_acnt, r_lcnt, r_lact;
    logic [CW-1:0] r_last_htot, r_last_hact;
    logic [CW-1:0] r_c_htot, r_c_hact, r_c_vtot, r_c_vact;

    logic          w_hs_rise, w_vs_rise, w_hbl_fall, w_vbl_fall;
    logic [CW-1:0] w_ltot, w_lact, w_ftot, w_fact, w_fh_tot, w_fh_act;
    logic          w_sat, w_line_mis, w_frame_mis, w_cand_eq;
    logic          w_err_nx, w_publish, w_cand_load;

    function automatic logic [CW-1:0] f_inc(input logic [CW-1:0] v);
        return (v == MAXV) ? v : v + ONE;
    endfunction

    assign w_hs_rise  = pxl_cen &  HS  & ~r_hs;
    assign w_vs_rise  = pxl_cen &  VS  & ~r_vs;
    assign w_hbl_fall = pxl_cen & ~HBL &  r_hbl;
    assign w_vbl_fall = pxl_cen & ~VBL &  r_vbl;

    // The pixel carrying the HS rise still belongs to the line it ends.
    assign w_ltot = f_inc(r_pcnt);
    assign w_lact = HBL ? r_acnt : f_inc(r_acnt);
    // Likewise an HS rise on the VS-rise pixel is counted into the ending frame.
    assign w_ftot = w_hs_rise ? f_inc(r_lcnt) : r_lcnt;
    assign w_fact = (w_hs_rise && !VBL) ? f_inc(r_lact) : r_lact;
    // Horizontal figures for a frame come from the last complete line.
    assign w_fh_tot = w_hs_rise ? w_ltot : r_last_htot;
    assign w_fh_act = w_hs_rise ? w_lact : r_last_hact;

    // Flag the step that takes an internal counter onto its ceiling.
    assign w_sat = pxl_cen && (r_state != ST_SEARCH) &&
                   ((!w_hs_rise && (r_pcnt == SAT_M1)) ||
                    (!w_hs_rise && !HBL && (r_acnt == SAT_M1)) ||
                    (w_hs_rise && !w_vs_rise && (r_lcnt == SAT_M1)) ||
                    (w_hs_rise && !w_vs_rise && !VBL && (r_lact == SAT_M1)));

    assign w_line_mis  = w_hs_rise && ((w_ltot != htotal) || (w_lact != hactive));
    assign w_frame_mis = w_vs_rise && ((w_ftot != vtotal) || (w_fact != vactive));
    assign w_cand_eq   = (w_fh_tot == r_c_htot) && (w_fh_act == r_c_hact) &&
                         (w_ftot == r_c_vtot) && (w_fact == r_c_vact);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_SEARCH;
        end else if (pxl_cen) begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; frame-level moves happen only on a VS rise.
    always_comb begin
        w_state_nx = r_state;
        if (w_sat) begin
            w_state_nx = ST_SEARCH;
        end else begin
            case (r_state)
                ST_SEARCH:  w_state_nx = w_vs_rise ? ST_MEASURE : ST_SEARCH;
                ST_MEASURE: w_state_nx = w_vs_rise ? ST_CHECK : ST_MEASURE;
                ST_CHECK:   w_state_nx = (w_vs_rise && w_cand_eq) ? ST_LOCKED : ST_CHECK;
                ST_LOCKED:  w_state_nx = (w_line_mis || w_frame_mis) ? ST_CHECK : ST_LOCKED;
                default:    w_state_nx = ST_SEARCH;
            endcase
        end
    end

    // Per-state actions: error pulse, candidate reload, publishing on lock.
    always_comb begin
        w_err_nx    = 1'b0;
        w_publish   = 1'b0;
        w_cand_load = 1'b0;
        if (w_sat) begin
            w_err_nx = 1'b1;
        end else begin
            case (r_state)
                ST_MEASURE: begin
                    w_cand_load = w_vs_rise;
                end
                ST_CHECK: begin
                    w_publish   = w_vs_rise & w_cand_eq;
                    w_cand_load = w_vs_rise & ~w_cand_eq;
                end
                ST_LOCKED: begin
                    w_err_nx    = w_line_mis | w_frame_mis;
                    w_cand_load = w_line_mis | w_frame_mis;
                end
                default: begin
                    w_err_nx    = 1'b0;
                    w_publish   = 1'b0;
                    w_cand_load = 1'b0;
                end
            endcase
        end
    end

    // Sampling, counters, candidate and published measurements.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            r_hbl       <= 1'b0;
            r_vbl       <= 1'b0;
            r_pcnt      <= '0;
            r_acnt      <= '0;
            r_lcnt      <= '0;
            r_lact      <= '0;
            r_last_htot <= '0;
            r_last_hact <= '0;
            r_c_htot    <= '0;
            r_c_hact    <= '0;
            r_c_vtot    <= '0;
            r_c_vact    <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            htotal      <= '0;
            hactive     <= '0;
            vtotal      <= '0;
            vactive     <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else if (pxl_cen) begin
            r_hs   <= HS;
            r_vs   <= VS;
            r_hbl  <= HBL;
            r_vbl  <= VBL;
            err    <= w_err_nx;
            locked <= (w_state_nx == ST_LOCKED);
            // Counting starts afresh on the VS rise that leaves SEARCH.
            if ((r_state == ST_SEARCH) || w_sat) begin
                r_pcnt      <= '0;
                r_acnt      <= '0;
                r_lcnt      <= '0;
                r_lact      <= '0;
                r_last_htot <= '0;
                r_last_hact <= '0;
                hcnt        <= '0;
                vcnt        <= '0;
            end else begin
                hcnt <= w_hbl_fall ? '0 : f_inc(hcnt);
                if (w_vbl_fall) begin
                    vcnt <= '0;
                end else if (w_hs_rise && !VBL) begin
                    vcnt <= f_inc(vcnt);
                end
                if (w_hs_rise) begin
                    r_pcnt      <= '0;
                    r_acnt      <= '0;
                    r_last_htot <= w_ltot;
                    r_last_hact <= w_lact;
                end else begin
                    r_pcnt <= f_inc(r_pcnt);
                    r_acnt <= w_lact;
                end
                if (w_vs_rise) begin
                    r_lcnt <= '0;
                    r_lact <= '0;
                end else begin
                    r_lcnt <= w_ftot;
                    r_lact <= w_fact;
                end
            end
            if (w_cand_load) begin
                r_c_htot <= w_fh_tot;
                r_c_hact <= w_fh_act;
                // A line mismatch mid-frame has no new frame figures yet.
                r_c_vtot <= w_vs_rise ? w_ftot : vtotal;
                r_c_vact <= w_vs_rise ? w_fact : vactive;
            end
            if (w_publish) begin
                htotal  <= w_fh_tot;
                hactive <= w_fh_act;
                vtotal  <= w_ftot;
                vactive <= w_fact;
            end
        end else begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtdd_sync_meas.sv
// Bench for jtdd_sync_meas. A scaled-down raster keeps the run short:
// 24 px/line (active x=0..15, HBL x=16..23, HS x=18..19), 16 lines/frame
// (active y=0..11, VBL y=12..15), VS rising together with the HS rise of
// line 13, pxl_cen every 4th clk. The stimulus pushes one expected record
// per pixel enable (and per reset clock); the monitor pops and compares.
module tb_jtdd_sync_meas;

    logic       clk = 1'b0;
    logic       rst, pxl_cen, HS, VS, HBL, VBL;
    logic [8:0] hcnt, vcnt, htotal, hactive, vtotal, vactive;
    logic       locked, err;

    jtdd_sync_meas #(.CW(9)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
        .HS(HS), .VS(VS), .HBL(HBL), .VBL(VBL),
        .hcnt(hcnt), .vcnt(vcnt), .htotal(htotal), .hactive(hactive),
        .vtotal(vtotal), .vactive(vactive), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int err;
        int locked;
        int geom;
        int chk_pos;
        int chk_zero;
        int hx;
        int vy;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected-state bookkeeping owned by the stimulus.
    bit exp_locked = 1'b0;
    bit geom_valid = 1'b0;
    bit in_search  = 1'b1;
    bit pos_ok     = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input bit e_err, input bit chk_pos, input int x, input int y);
        exp_t t;
        t.err      = e_err;
        t.locked   = exp_locked;
        t.geom     = geom_valid;
        t.chk_pos  = chk_pos;
        t.chk_zero = in_search;
        t.hx       = x;
        t.vy       = y;
        q.push_back(t);
    endtask

    task automatic cen_pix(input bit hs, input bit vs, input bit hbl, input bit vbl,
                           input bit e_err, input bit chk_pos, input int x, input int y);
        @(negedge clk);
        HS = hs; VS = vs; HBL = hbl; VBL = vbl;
        pxl_cen = 1'b1;
        push(e_err, chk_pos, x, y);
        @(negedge clk);
        pxl_cen = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        exp_locked = 1'b0;
        geom_valid = 1'b0;
        in_search  = 1'b1;
        pos_ok     = 1'b0;
        push(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One frame; long_y gets a 25th pixel, rst_y resets after pixel (rst_y,5).
    task automatic frame(input int nlines, input int long_y, input bit lock_vs,
                         input bit err_vs, input int rst_y);
        for (int y = 0; y < nlines; y++) begin
            int w;
            w = (y == long_y) ? 25 : 24;
            for (int x = 0; x < w; x++) begin
                bit hs, vs, hbl, vbl, e_err, chk;
                hs    = (x == 18) || (x == 19);
                hbl   = (x >= 16);
                vbl   = (y >= 12);
                vs    = ((y == 13) && (x >= 18)) || ((y == 14) && (x < 18));
                e_err = 1'b0;
                if ((y == 13) && (x == 18)) begin
                    if (in_search) begin
                        in_search = 1'b0;
                    end else if (lock_vs) begin
                        exp_locked = 1'b1;
                        geom_valid = 1'b1;
                    end else if (err_vs) begin
                        e_err      = 1'b1;
                        exp_locked = 1'b0;
                    end
                end
                if ((long_y >= 0) && (y == long_y + 1) && (x == 18)) begin
                    e_err      = 1'b1;
                    exp_locked = 1'b0;
                end
                chk = pos_ok && !in_search && (x < 16) && (y < 12);
                cen_pix(hs, vs, hbl, vbl, e_err, chk, x, y);
                if ((y == rst_y) && (x == 5)) do_reset();
            end
        end
        if (!in_search) pos_ok = 1'b1;
    endtask

    // All inputs low: pcnt is 5 after the last line, so it reaches 511 on cen 506.
    task automatic hold_low(input int ncen);
        for (int k = 1; k <= ncen; k++) begin
            bit e_err;
            e_err = (k == 506);
            if (e_err) begin
                exp_locked = 1'b0;
                in_search  = 1'b1;
                pos_ok     = 1'b0;
            end
            cen_pix(1'b0, 1'b0, 1'b0, 1'b0, e_err, 1'b0, 0, 0);
        end
    endtask

    // Monitor: compares on every pixel-enable or reset clock, err idle otherwise.
    always @(posedge clk) begin
        if (!rst || pxl_cen) begin
            #1;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL queue_underflow: DUT output with no expected record at %0t", $time);
            end else begin
                mon_e = q.pop_front();
                check("err", int'(err), mon_e.err);
                check("locked", int'(locked), mon_e.locked);
                check("htotal", int'(htotal), mon_e.geom ? 24 : 0);
                check("hactive", int'(hactive), mon_e.geom ? 16 : 0);
                check("vtotal", int'(vtotal), mon_e.geom ? 16 : 0);
                check("vactive", int'(vactive), mon_e.geom ? 12 : 0);
                if (mon_e.chk_pos != 0) begin
                    check("hcnt", int'(hcnt), mon_e.hx);
                    check("vcnt", int'(vcnt), mon_e.vy);
                end
                if (mon_e.chk_zero != 0) begin
                    check("hcnt_search", int'(hcnt), 0);
                    check("vcnt_search", int'(vcnt), 0);
                end
            end
        end else begin
            #1;
            check("err_idle", int'(err), 0);
        end
    end

    initial begin
        rst = 1'b0; pxl_cen = 1'b0;
        HS = 1'b0; VS = 1'b0; HBL = 1'b0; VBL = 1'b0;
        repeat (3) push(1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Lock from reset on the third VS rise, then one steady frame.
        frame(16, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b1, 1'b0, -1);
        frame(16, -1, 1'b0, 1'b0, -1);
        // One 25-pixel line: err at the next HS rise, relock after 2 VS rises.
        frame(16, 3, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b1, 1'b0, -1);
        frame(16, -1, 1'b0, 1'b0, -1);
        // Dead input: saturation error, SEARCH, relock on the third VS rise.
        hold_low(600);
        frame(16, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b1, 1'b0, -1);
        // Mid-frame reset while locked.
        frame(16, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b0, 1'b0, 5);
        frame(16, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b1, 1'b0, -1);
        // Alternating 17/16-line frames never lock; steady 16 locks again.
        frame(17, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b0, 1'b1, -1);
        frame(17, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b0, 1'b0, -1);
        frame(17, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b0, 1'b0, -1);
        frame(16, -1, 1'b1, 1'b0, -1);
        frame(16, -1, 1'b0, 1'b0, -1);

        repeat (8) @(negedge clk);
        check("queue_drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: stimulus did not complete by %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
